// File: rtl/mem_access_sequencer.sv
// Memory transaction sequencer: round-robin arbitration between fetch and data
// requests, address-mux select, read/write strobes with ready timeout, data capture.
module mem_access_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  fetchReq,
  input  logic                  dataReq,
  input  logic                  dataWrite,
  input  logic [DATA_WIDTH-1:0] storeData,
  input  logic [DATA_WIDTH-1:0] memDataIn,
  input  logic                  memReady,
  output logic                  select,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [DATA_WIDTH-1:0] memDataOut,
  output logic [DATA_WIDTH-1:0] instrOut,
  output logic                  instrValid,
  output logic [DATA_WIDTH-1:0] loadDataOut,
  output logic                  dataDone,
  output logic                  busError,
  output logic                  busy
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_data_q, last_data_d;
  logic                  gnt_data_q, gnt_data_d;
  logic                  write_q, write_d;
  logic                  select_q, select_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] load_q, load_d;
  logic                  iv_q, iv_d;
  logic                  dd_q, dd_d;
  logic                  berr_q, berr_d;
  logic                  busy_q, busy_d;
  logic                  take_data;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    gnt_data_d  = gnt_data_q;
    write_d     = write_q;
    select_d    = select_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    dout_d      = dout_q;
    instr_d     = instr_q;
    load_d      = load_q;
    iv_d        = 1'b0;
    dd_d        = 1'b0;
    berr_d      = berr_q;
    take_data   = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetchReq || dataReq) begin
          // Under contention the requester not served last time wins
          take_data   = dataReq && (!fetchReq || !last_data_q);
          gnt_data_d  = take_data;
          last_data_d = take_data;
          select_d    = take_data;
          write_d     = dataWrite;
          dout_d      = storeData;
          berr_d      = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
        if (gnt_data_q && write_q) begin
          wr_d = 1'b1;
        end else begin
          rd_d = 1'b1;
        end
      end
      ACCESS: begin
        if (memReady) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
          if (!gnt_data_q) begin
            instr_d = memDataIn;
          end else if (!write_q) begin
            load_d = memDataIn;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          berr_d  = 1'b1;
          state_d = DONE;
          if (!gnt_data_q) begin
            instr_d = '0;
          end else if (!write_q) begin
            load_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        iv_d    = !gnt_data_q;
        dd_d    = gnt_data_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_data_q <= 1'b1;
      gnt_data_q  <= 1'b0;
      write_q     <= 1'b0;
      select_q    <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      dout_q      <= '0;
      instr_q     <= '0;
      load_q      <= '0;
      iv_q        <= 1'b0;
      dd_q        <= 1'b0;
      berr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      gnt_data_q  <= gnt_data_d;
      write_q     <= write_d;
      select_q    <= select_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      dout_q      <= dout_d;
      instr_q     <= instr_d;
      load_q      <= load_d;
      iv_q        <= iv_d;
      dd_q        <= dd_d;
      berr_q      <= berr_d;
      busy_q      <= busy_d;
    end
  end

  assign select      = select_q;
  assign memRead     = rd_q;
  assign memWrite    = wr_q;
  assign memDataOut  = dout_q;
  assign instrOut    = instr_q;
  assign instrValid  = iv_q;
  assign loadDataOut = load_q;
  assign dataDone    = dd_q;
  assign busError    = berr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: expected completions are queued at
// request time and checked when instrValid/dataDone pulse.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        fetchReq, dataReq, dataWrite, memReady;
  logic [31:0] storeData, memDataIn;
  logic        select, memRead, memWrite, instrValid, dataDone, busError, busy;
  logic [31:0] memDataOut, instrOut, loadDataOut;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_sequencer dut (
    .clk(clk), .resetN(resetN), .fetchReq(fetchReq), .dataReq(dataReq),
    .dataWrite(dataWrite), .storeData(storeData), .memDataIn(memDataIn),
    .memReady(memReady), .select(select), .memRead(memRead), .memWrite(memWrite),
    .memDataOut(memDataOut), .instrOut(instrOut), .instrValid(instrValid),
    .loadDataOut(loadDataOut), .dataDone(dataDone), .busError(busError), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Completion monitor: pops one expected entry per done pulse
  always @(negedge clk) begin
    if (instrValid || dataDone) begin
      if (sb.size() == 0) begin
        check("sb_empty_pulse", {instrValid, dataDone}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_src", {30'd0, instrValid, dataDone}, (e.kind == 2'd0) ? 32'd2 : 32'd1);
        check("done_data", (e.kind == 2'd0) ? instrOut :
                           (e.kind == 2'd1) ? loadDataOut : memDataOut, e.data);
        check("done_berr", busError, e.err);
      end
    end
  end

  // kind: 0 fetch, 1 load, 2 store; ws < 0 means memReady never comes
  task automatic run_txn(input string tag, input logic [1:0] kind, input logic [31:0] sd,
                         input logic [31:0] rdata, input int ws, input bit early,
                         input int exp_pulse, input int exp_rd, input int exp_wr);
    exp_t e;
    int   pulse_at = -1;
    int   rd_cyc = 0, wr_cyc = 0, sel_bad = 0, acc = 0;
    bit   is_data;
    is_data = (kind != 2'd0);
    if (is_data) dataReq = 1'b1; else fetchReq = 1'b1;
    dataWrite = (kind == 2'd2);
    storeData = sd;
    memReady  = early;
    memDataIn = 32'hBADBAD00;
    e.kind = kind;
    e.data = (kind == 2'd2) ? sd : ((ws < 0) ? 32'd0 : rdata);
    e.err  = (ws < 0);
    sb.push_back(e);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check({tag, "_berr_clr"}, busError, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
      end
      if (memRead) rd_cyc++;
      if (memWrite) wr_cyc++;
      if (select !== is_data) sel_bad++;
      if (is_data ? dataDone : instrValid) begin
        pulse_at = i;
        if (is_data) dataReq = 1'b0; else fetchReq = 1'b0;
        memReady = 1'b0;
        break;
      end
      if (memRead || memWrite) begin
        memReady  = (ws >= 0) && (acc >= ws);
        memDataIn = rdata;
        acc++;
      end else begin
        memReady  = (i == 1) ? early : 1'b0;
        memDataIn = 32'hBADBAD00;
      end
    end
    check({tag, "_pulse_at"}, pulse_at, exp_pulse);
    check({tag, "_rd_cycles"}, rd_cyc, exp_rd);
    check({tag, "_wr_cycles"}, wr_cyc, exp_wr);
    check({tag, "_select"}, sel_bad, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   g;
    bit   prev_busy;
    logic gsel [4];
    int   gat  [4];
    exp_t e;

    resetN = 1'b0; fetchReq = 1'b0; dataReq = 1'b0; dataWrite = 1'b0;
    memReady = 1'b0; storeData = '0; memDataIn = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", {select, memRead, memWrite, instrValid, dataDone, busError, busy}, 32'd0);
    check("rst_instr", instrOut, 32'd0);
    check("rst_load", loadDataOut, 32'd0);
    check("rst_dout", memDataOut, 32'd0);
    resetN = 1'b1;

    run_txn("fetch0", 2'd0, 32'd0, 32'hE3A01005, 0, 1'b0, 4, 1, 0);

    // memReady in IDLE without a request: no activity, no capture
    memDataIn = 32'h0BAD0BAD;
    memReady  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_rdy_busy", busy, 1'b0);
      check("idle_rdy_instr", instrOut, 32'hE3A01005);
    end
    memReady = 1'b0;

    run_txn("fetch_early", 2'd0, 32'd0, 32'h12345678, 3, 1'b1, 7, 4, 0);
    run_txn("store", 2'd2, 32'hDEADBEEF, 32'd0, 2, 1'b0, 6, 0, 3);
    run_txn("load_tmo", 2'd1, 32'd0, 32'h77777777, -1, 1'b0, 18, 15, 0);
    run_txn("load_ok", 2'd1, 32'd0, 32'hCAFEF00D, 0, 1'b0, 4, 1, 0);
    check("instr_hold", instrOut, 32'h12345678);

    // Reset in ACCESS of a load aborts without a done pulse
    @(negedge clk);
    dataReq = 1'b1; dataWrite = 1'b0; memReady = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_pre_rd", memRead, 1'b1);
    #2 resetN = 1'b0;
    #1;
    check("abort_outs", {select, memRead, memWrite, dataDone, busError, busy}, 32'd0);
    check("abort_load", loadDataOut, 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    run_txn("regrant", 2'd1, 32'd0, 32'h5A5AA5A5, 1, 1'b0, 5, 2, 0);

    // Both requests held: grants must alternate fetch/data every 4 cycles
    do_reset();
    fetchReq = 1'b1; dataReq = 1'b1; dataWrite = 1'b0; memReady = 1'b0;
    memDataIn = 32'hA5A50F0F;
    for (int k = 0; k < 4; k++) begin
      e.kind = (k % 2 == 0) ? 2'd0 : 2'd1;
      e.data = 32'hA5A50F0F;
      e.err  = 1'b0;
      sb.push_back(e);
    end
    g = 0;
    prev_busy = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (busy && !prev_busy && g < 4) begin
        gsel[g] = select;
        gat[g]  = i;
        g++;
        if (g == 4) begin
          fetchReq = 1'b0;
          dataReq  = 1'b0;
        end
      end
      prev_busy = busy;
      memReady  = memRead | memWrite;
    end
    check("rr_grants", g, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < g) begin
        check($sformatf("rr_sel%0d", k), gsel[k], (k % 2 == 0) ? 1'b0 : 1'b1);
        if (k > 0) check($sformatf("rr_gap%0d", k), gat[k] - gat[k-1], 4);
      end
    end

    repeat (2) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
